// File: rtl/signal_selector_pkt_if.sv
// AXI-Stream bundle (data, valid, last, ready) shared by the direct input,
// the feedback input and the selected output of signal_selector_pkt.
interface signal_selector_pkt_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/signal_selector_pkt.sv
// signal_selector_pkt: picks the direct stream or one band slice of the
// feedback stream, switching only on packet boundaries, and registers the
// chosen stream through a 2-entry skid buffer.
// Optional macro SIGNAL_SELECTOR_DROP_CNT_EN adds po_drop_cnt, a saturating
// count of beats drained from the non-selected source.
module signal_selector_pkt #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANDS  = 3,
  parameter int SEL_WIDTH  = $clog2(NUM_BANDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_WIDTH-1:0] pi_sel,
  signal_selector_pkt_if.slave  s_data,
  signal_selector_pkt_if.slave  s_fb,
  signal_selector_pkt_if.master m,
  output logic [SEL_WIDTH-1:0] po_active_sel,
  output logic                 po_sel_pending,
  output logic                 po_switch
`ifdef SIGNAL_SELECTOR_DROP_CNT_EN
  ,
  output logic [15:0]          po_drop_cnt
`endif
);

  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(NUM_BANDS);

  logic [SEL_WIDTH-1:0]  sel_clamped;
  logic [SEL_WIDTH-1:0]  sel_next;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_valid;
  logic                  src_last;
  logic                  src_ready;
  logic                  accept;
  logic                  pop;
  logic                  in_pkt;
  logic                  in_pkt_next;
  logic [DATA_WIDTH-1:0] spare_data;
  logic                  spare_last;
  logic                  spare_valid;
  logic                  head_valid_next;
  logic                  spare_valid_next;
  logic                  full_next;
  logic                  head_load_src;
  logic                  head_load_spare;
  logic                  spare_load;

  // Clamp the request and route the currently active source onto src_*.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    sel_clamped = (pi_sel > MAX_SEL) ? MAX_SEL : pi_sel;
    src_data    = s_data.tdata;
    src_valid   = s_data.tvalid;
    src_last    = s_data.tlast;
    src_ready   = s_data.tready;
    if (po_active_sel != '0) begin
      src_valid = s_fb.tvalid;
      src_last  = s_fb.tlast;
      src_ready = s_fb.tready;
      src_data  = '0;
      for (int k = 1; k <= NUM_BANDS; k++) begin
        if (po_active_sel == SEL_WIDTH'(k))
          src_data = s_fb.tdata[(NUM_BANDS-k+1)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

  // Handshakes, packet boundary tracking and skid-buffer occupancy.
  always_comb begin
    accept      = src_valid && src_ready;
    pop         = m.tvalid && m.tready;
    in_pkt_next = accept ? !src_last : in_pkt;
    // A boundary is an accepted tlast beat, or an idle cycle outside a packet.
    sel_next    = (accept ? src_last : !in_pkt) ? sel_clamped : po_active_sel;

    head_valid_next  = m.tvalid;
    spare_valid_next = spare_valid;
    if (pop) begin
      head_valid_next  = spare_valid || accept;
      spare_valid_next = spare_valid && accept;
    end else if (accept) begin
      head_valid_next  = 1'b1;
      spare_valid_next = m.tvalid;
    end
    full_next = head_valid_next && spare_valid_next;

    head_load_spare = pop && spare_valid;
    head_load_src   = accept && (pop ? !spare_valid : !m.tvalid);
    spare_load      = accept && (pop ? spare_valid : m.tvalid);
  end

  // Control state, registered readies and the output head register.
  always_ff @(posedge clk) begin
    // NOTE: state uses <= so every register samples pre-edge values.
    if (rst) begin
      in_pkt         <= 1'b0;
      po_active_sel  <= '0;
      po_switch      <= 1'b0;
      po_sel_pending <= 1'b0;
      spare_valid    <= 1'b0;
      m.tvalid       <= 1'b0;
      m.tdata        <= '0;
      m.tlast        <= 1'b0;
      s_data.tready  <= 1'b0;
      s_fb.tready    <= 1'b0;
    end else begin
      in_pkt         <= in_pkt_next;
      po_active_sel  <= sel_next;
      po_switch      <= (sel_next != po_active_sel);
      po_sel_pending <= in_pkt_next && (sel_clamped != sel_next);
      spare_valid    <= spare_valid_next;
      m.tvalid       <= head_valid_next;
      // The non-selected source is always drained so it never stalls upstream.
      s_data.tready  <= (sel_next == '0) ? !full_next : 1'b1;
      s_fb.tready    <= (sel_next != '0) ? !full_next : 1'b1;
      if (head_load_spare) begin
        m.tdata <= spare_data;
        m.tlast <= spare_last;
      end else if (head_load_src) begin
        m.tdata <= src_data;
        m.tlast <= src_last;
      end
    end
  end

  // Spare skid entry payload.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; spare_valid alone marks the entry empty.
    if (spare_load) begin
      spare_data <= src_data;
      spare_last <= src_last;
    end
  end

`ifdef SIGNAL_SELECTOR_DROP_CNT_EN
  logic drop_beat;
  assign drop_beat = (po_active_sel == '0) ? (s_fb.tvalid && s_fb.tready)
                                           : (s_data.tvalid && s_data.tready);

  // Saturating count of discarded beats, cleared whenever the selection moves.
  always_ff @(posedge clk) begin
    if (rst)
      po_drop_cnt <= '0;
    else if (sel_next != po_active_sel)
      po_drop_cnt <= '0;
    else if (drop_beat && (po_drop_cnt != 16'hFFFF))
      po_drop_cnt <= po_drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_signal_selector_pkt.sv
// Self-checking bench for signal_selector_pkt: directed steps with random
// payloads plus a random phase, all checked every cycle against a
// queue-based reference model of the selector.
module tb_signal_selector_pkt;
  localparam int DW = 16;
  localparam int NB = 3;
  localparam int SW = 3;

  typedef struct packed { logic [DW-1:0] data; logic last; } out_t;
  typedef struct packed { logic [NB*DW-1:0] data; logic last; } in_t;

  logic          clk;
  logic          rst;
  logic [SW-1:0] pi_sel;
  logic [SW-1:0] po_active_sel;
  logic          po_sel_pending;
  logic          po_switch;
`ifdef SIGNAL_SELECTOR_DROP_CNT_EN
  logic [15:0]   po_drop_cnt;
`endif

  signal_selector_pkt_if #(.WIDTH(DW))    s_data_if ();
  signal_selector_pkt_if #(.WIDTH(NB*DW)) s_fb_if ();
  signal_selector_pkt_if #(.WIDTH(DW))    m_if ();

  signal_selector_pkt #(.DATA_WIDTH(DW), .NUM_BANDS(NB), .SEL_WIDTH(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pi_sel         (pi_sel),
    .s_data         (s_data_if),
    .s_fb           (s_fb_if),
    .m              (m_if),
    .po_active_sel  (po_active_sel),
    .po_sel_pending (po_sel_pending),
    .po_switch      (po_switch)
`ifdef SIGNAL_SELECTOR_DROP_CNT_EN
    ,
    .po_drop_cnt    (po_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Source stimulus queues and observed output beats.
  in_t  dq[$];
  in_t  fq[$];
  out_t obs[$];

  // Reference model state.
  out_t mq[$];
  int   act;
  bit   in_pkt, pend, sw, ready_en;
  int   drop;
  int   acc_cnt;
  bit   d_hold, f_hold;
  bit   gaps;
  bit   armed;

  function automatic int clamp(int s);
    return (s > NB) ? NB : s;
  endfunction

  function automatic logic [DW-1:0] band(logic [NB*DW-1:0] w, int k);
    logic [NB*DW-1:0] t;
    t = w >> ((NB - k) * DW);
    return t[DW-1:0];
  endfunction

  task automatic check(string tag, logic [47:0] observed, logic [47:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Compare DUT outputs to the model, then advance the model across the edge.
  task automatic model_step();
    bit d_rdy, f_rdy, d_take, f_take, acc, nonsel;
    out_t b;
    int new_act;
    if (armed) begin
      check("m_tvalid", 48'(m_if.tvalid), 48'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("m_tdata", 48'(m_if.tdata), 48'(mq[0].data));
        check("m_tlast", 48'(m_if.tlast), 48'(mq[0].last));
      end
      check("s_data_tready", 48'(s_data_if.tready), 48'(ready_en && (act != 0 || mq.size() < 2)));
      check("s_fb_tready", 48'(s_fb_if.tready), 48'(ready_en && (act == 0 || mq.size() < 2)));
      check("po_active_sel", 48'(po_active_sel), 48'(act));
      check("po_sel_pending", 48'(po_sel_pending), 48'(pend));
      check("po_switch", 48'(po_switch), 48'(sw));
`ifdef SIGNAL_SELECTOR_DROP_CNT_EN
      check("po_drop_cnt", 48'(po_drop_cnt), 48'(drop));
`endif
      if (m_if.tvalid && m_if.tready) obs.push_back({m_if.tdata, m_if.tlast});
    end
    if (rst) begin
      mq.delete();
      act = 0; in_pkt = 0; pend = 0; sw = 0; ready_en = 0; drop = 0;
      d_hold = 0; f_hold = 0;
    end else begin
      d_rdy  = ready_en && (act != 0 || mq.size() < 2);
      f_rdy  = ready_en && (act == 0 || mq.size() < 2);
      d_take = s_data_if.tvalid && d_rdy;
      f_take = s_fb_if.tvalid && f_rdy;
      acc    = (act == 0) ? d_take : f_take;
      nonsel = (act == 0) ? f_take : d_take;
      b.data = (act == 0) ? s_data_if.tdata : band(s_fb_if.tdata, act);
      b.last = (act == 0) ? s_data_if.tlast : s_fb_if.tlast;
      if (mq.size() > 0 && m_if.tready) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(b);
        acc_cnt++;
      end
      new_act = (acc ? b.last : !in_pkt) ? clamp(int'(pi_sel)) : act;
      if (acc) in_pkt = !b.last;
      sw = (new_act != act);
      if (sw) drop = 0;
      else if (nonsel && drop < 65535) drop++;
      act      = new_act;
      pend     = in_pkt && (clamp(int'(pi_sel)) != act);
      ready_en = 1;
      d_hold   = s_data_if.tvalid && !d_take;
      f_hold   = s_fb_if.tvalid && !f_take;
      if (d_take) void'(dq.pop_front());
      if (f_take) void'(fq.pop_front());
    end
  endtask

  // One clock: drive sources from their queues, check at negedge, settle after posedge.
  task automatic cycle();
    bit gd, gf;
    gd = !gaps || ($urandom_range(0, 3) != 0);
    gf = !gaps || ($urandom_range(0, 3) != 0);
    s_data_if.tvalid = (dq.size() > 0) && (d_hold || gd);
    s_fb_if.tvalid   = (fq.size() > 0) && (f_hold || gf);
    if (dq.size() > 0) begin
      s_data_if.tdata = dq[0].data[DW-1:0];
      s_data_if.tlast = dq[0].last;
    end
    if (fq.size() > 0) begin
      s_fb_if.tdata = fq[0].data;
      s_fb_if.tlast = fq[0].last;
    end
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int extra);
    int n = 0;
    while ((dq.size() > 0 || fq.size() > 0) && n < 300) begin
      cycle();
      n++;
    end
    check("drain_timeout", 48'(dq.size() + fq.size()), 48'(0));
    repeat (extra) cycle();
  endtask

  task automatic wait_acc(int k);
    int start = acc_cnt;
    int n = 0;
    while (acc_cnt < start + k && n < 50) begin
      cycle();
      n++;
    end
    check("accept_timeout", 48'(acc_cnt >= start + k), 48'(1));
  endtask

  task automatic push_d(int len);
    for (int i = 0; i < len; i++) dq.push_back({32'(0), 16'($urandom), i == len - 1});
  endtask

  task automatic push_f(int len);
    for (int i = 0; i < len; i++) fq.push_back({16'($urandom), $urandom, i == len - 1});
  endtask

  initial begin
    logic [2:0]      sels[4];
    logic [DW-1:0]   exps[4];
    logic [DW-1:0]   held;
    logic [NB*DW-1:0] w;
    in_t             sent[$];

    sels = '{3'd2, 3'd3, 3'd1, 3'd7};
    exps = '{16'hBBBB, 16'hCCCC, 16'hAAAA, 16'hCCCC};
    rst = 1'b1; pi_sel = '0; gaps = 0; armed = 0; acc_cnt = 0;
    m_if.tready = 1'b1;
    s_data_if.tvalid = 1'b0; s_data_if.tdata = '0; s_data_if.tlast = 1'b0;
    s_fb_if.tvalid = 1'b0;   s_fb_if.tdata = '0;   s_fb_if.tlast = 1'b0;
    act = 0; in_pkt = 0; pend = 0; sw = 0; ready_en = 0; drop = 0;
    d_hold = 0; f_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    armed = 1;
    cycle();
    check("rst_m_tvalid", 48'(m_if.tvalid), 48'(0));
    check("rst_m_tdata", 48'(m_if.tdata), 48'(0));
    check("rst_m_tlast", 48'(m_if.tlast), 48'(0));
    check("rst_s_data_tready", 48'(s_data_if.tready), 48'(0));
    check("rst_s_fb_tready", 48'(s_fb_if.tready), 48'(0));
    check("rst_active_sel", 48'(po_active_sel), 48'(0));
    rst = 1'b0;

    // Ten feedback beats drained while direct is selected, then switch away.
    push_f(10);
    drain(0);
`ifdef SIGNAL_SELECTOR_DROP_CNT_EN
    check("drop_cnt_10", 48'(po_drop_cnt), 48'(10));
`endif
    pi_sel = 3'd1;
    cycle();
    check("switch_pulse", 48'(po_switch), 48'(1));
`ifdef SIGNAL_SELECTOR_DROP_CNT_EN
    check("drop_cnt_clear", 48'(po_drop_cnt), 48'(0));
`endif
    pi_sel = 3'd0;
    repeat (2) cycle();

    // Direct packet 1..4 with feedback traffic drained alongside.
    obs.delete();
    for (int i = 1; i <= 4; i++) dq.push_back({32'(0), 16'(i), i == 4});
    push_f(4);
    drain(3);
    check("direct_count", 48'(obs.size()), 48'(4));
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      check("direct_data", 48'(obs[i].data), 48'(i + 1));
      check("direct_last", 48'(obs[i].last), 48'(i == 3));
    end

    // Band slicing, including a clamped request.
    for (int s = 0; s < 4; s++) begin
      pi_sel = sels[s];
      repeat (2) cycle();
      check("band_active_sel", 48'(po_active_sel), 48'(clamp(int'(sels[s]))));
      obs.delete();
      fq.push_back({48'hAAAA_BBBB_CCCC, 1'b1});
      drain(3);
      check("band_count", 48'(obs.size()), 48'(1));
      if (obs.size() > 0) check("band_data", 48'(obs[0].data), 48'(exps[s]));
    end

    // Mid-packet request: the direct packet completes before band 1 takes over.
    pi_sel = 3'd0;
    repeat (2) cycle();
    obs.delete();
    push_d(5);
    sent = dq;
    wait_acc(2);
    pi_sel = 3'd1;
    cycle();
    check("midpkt_pending", 48'(po_sel_pending), 48'(1));
    check("midpkt_hold_sel", 48'(po_active_sel), 48'(0));
    drain(3);
    check("midpkt_count", 48'(obs.size()), 48'(5));
    for (int i = 0; i < 5 && i < obs.size(); i++)
      check("midpkt_data", 48'(obs[i].data), 48'(sent[i].data[DW-1:0]));
    check("midpkt_new_sel", 48'(po_active_sel), 48'(1));
    obs.delete();
    w = {16'($urandom), $urandom};
    fq.push_back({w, 1'b1});
    drain(3);
    if (obs.size() > 0) check("midpkt_band1", 48'(obs[0].data), 48'(w[47:32]));
    else check("midpkt_band1_count", 48'(obs.size()), 48'(1));

    // Output stalled for six cycles behind a continuous direct source.
    pi_sel = 3'd0;
    repeat (2) cycle();
    obs.delete();
    push_d(12);
    sent = dq;
    m_if.tready = 1'b0;
    cycle();
    cycle();
    held = m_if.tdata;
    repeat (4) cycle();
    check("stall_tready", 48'(s_data_if.tready), 48'(0));
    check("stall_stable", 48'(m_if.tdata), 48'(held));
    check("stall_first", 48'(m_if.tdata), 48'(sent[0].data[DW-1:0]));
    m_if.tready = 1'b1;
    drain(4);
    check("stall_count", 48'(obs.size()), 48'(12));
    for (int i = 0; i < 12 && i < obs.size(); i++)
      check("stall_order", 48'(obs[i].data), 48'(sent[i].data[DW-1:0]));

    // Reset in the middle of a packet, request 7 clamps to band 3.
    push_d(6);
    wait_acc(2);
    rst = 1'b1;
    dq.delete();
    fq.delete();
    pi_sel = 3'd7;
    cycle();
    check("midrst_m_tvalid", 48'(m_if.tvalid), 48'(0));
    check("midrst_s_data_tready", 48'(s_data_if.tready), 48'(0));
    check("midrst_s_fb_tready", 48'(s_fb_if.tready), 48'(0));
    rst = 1'b0;
    cycle();
    check("midrst_sel", 48'(po_active_sel), 48'(3));
    obs.delete();
    w = {16'($urandom), $urandom};
    fq.push_back({w, 1'b1});
    drain(3);
    if (obs.size() > 0) check("midrst_band3", 48'(obs[0].data), 48'(w[15:0]));
    else check("midrst_band3_count", 48'(obs.size()), 48'(1));

    // Random traffic, gaps, backpressure and selection changes.
    gaps = 1;
    for (int c = 0; c < 600; c++) begin
      if (dq.size() == 0) push_d($urandom_range(1, 4));
      if (fq.size() == 0) push_f($urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0) pi_sel = 3'($urandom_range(0, 7));
      m_if.tready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    m_if.tready = 1'b1;
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
